ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. Sends command bytes to the keyboard (LEDs 0xED, enable 0xF4, reset 0xFF) over the same open-drain clock/data pins the keyboard receive logic samples.
- Memory-mapped: CPU writes a byte; the block runs the inhibit/request-to-send/11-clock/ack sequence; CPU polls status.
- Drive enables are OR-combined with any other drivers at top level.

Parameters:
INHIBIT_CYCLES, 5000, clock cycles the clock line is held low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, max cycles from clock release to ack before aborting (20 ms at 50 MHz).

Ports:
clock  in  1  core clock; all state changes on rising edge.
reset  in  1  synchronous reset, active-low (reset==0 resets state at the next clock edge).
ps2_clk_i  in  1  PS/2 clock pin level (async).
ps2_clk_o  out  1  clock drive value; constant 0.
ps2_clk_d  out  1  clock drive enable; 1 = pull low, 0 = released.
ps2_data_i  in  1  PS/2 data pin level (async).
ps2_data_o  out  1  data drive value; constant 0.
ps2_data_d  out  1  data drive enable; 1 = pull low, 0 = released.
mmioInData  in  32  write data.
mmioOutData  out  32  read data, registered.
mmioAddr  in  32  address.
mmioOpm  in  5  bit3 = read, bit4 = write.
mmioOK  out  2  UMEM_OK_READY idle, UMEM_OK_OK on a selected access; registered.
ps2tx_irq  out  1  completion interrupt (see Optional Feature).

Behaviour:
- Select: mmioAddr[27:16]==12'h000 and mmioAddr[15:4]==12'hE08.
- Offset 0x0 (write): TXDATA; the byte is mmioInData[7:0].
- Offset 0x4 (read): STATUS. bit0 busy, bit1 ack_ok, bit2 err (timeout or no ack), bit3 overrun. Other bits 0.
- MMIO response: outputs registered, valid the cycle after the access. Unselected cycles give mmioOK=UMEM_OK_READY and mmioOutData=0.
- Reset values: all drive enables 0; mmioOutData=0; mmioOK=UMEM_OK_READY; status=0; state IDLE; ps2tx_irq=0.
- Input sync: 2-flop synchronisers on ps2_clk_i and ps2_data_i. A falling edge is detected when sync2==1 and sync1==0.
- Frame: shift register {stop=1, parity, d[7:0]}. Parity is odd: ~^d. Bits go out LSB first.

FSM:
- IDLE: a write to TXDATA latches the frame, clears ack_ok/err, sets busy -> INHIBIT.
- INHIBIT: clk_d=1; count to INHIBIT_CYCLES -> RTS.
- RTS (1 cycle): data_d=1 (start bit), clk_d=0; load the timeout counter -> BITS.
- BITS: on each falling edge, data_d = ~bit[i], i=0..9. Edges 1-8 carry d0..d7, edge 9 carries parity, edge 10 carries stop (data released). After edge 10 -> ACK.
- ACK: on the next falling edge, sample data. Sampled 0 sets ack_ok; sampled 1 sets err. -> WAITIDLE.
- WAITIDLE: wait until sync clk and sync data are both 1 -> IDLE; busy=0.
- Timeout: the counter decrements every cycle in BITS/ACK/WAITIDLE. On reaching 0: release both lines, err=1, busy=0 -> IDLE.
- Write while busy: byte dropped, overrun=1. The frame in flight is unaffected.
- A TXDATA write in the same cycle busy clears is treated as busy (dropped).
- Reading STATUS clears overrun and err. ack_ok persists until the next accepted write.
- Reset mid-frame: lines released on the next edge; status cleared.

Optional Feature:
- Macro: PS2TX_IRQ_EN.
- Defined: ps2tx_irq goes high when busy falls (ack or error) and stays high until a STATUS read; a STATUS read and a completion in the same cycle leave it set.
- Undefined: ps2tx_irq is tied 0 and no IRQ state exists.

Test Plan:
- Write 0xED; device model clocks at 12 kHz and acks -> clk held low ≥5000 cycles; data bits at edges 1-10 read 1,0,1,1,0,1,1,1, parity 1, stop 1; STATUS=0x2.
- Write 0xF4 with acking model -> parity bit 0; busy=1 mid-frame; final STATUS=0x2.
- Write 0xFF; model leaves data high at the 11th clock -> STATUS=0x4 after idle; a second STATUS read returns 0x0.
- Write 0x00; model never clocks -> after 1000000 cycles both drives are 0 and STATUS=0x4.
- Write 0xED then 0x01 during INHIBIT -> only 0xED is transmitted; STATUS=0x0A (ack_ok + overrun); next read returns 0x02.
- Assert reset=0 for one cycle at edge 5 of a frame -> clk_d=data_d=0 and STATUS=0x0 from the following cycle; with PS2TX_IRQ_EN, irq asserts after a completed frame and clears on the STATUS read.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-clock frame, ack; MMIO TXDATA/STATUS.
// Optional build macro PS2TX_IRQ_EN enables the completion interrupt on ps2tx_irq.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk_i,
  output logic        ps2_clk_o,
  output logic        ps2_clk_d,
  input  logic        ps2_data_i,
  output logic        ps2_data_o,
  output logic        ps2_data_d,
  input  logic [31:0] mmioInData,
  output logic [31:0] mmioOutData,
  input  logic [31:0] mmioAddr,
  input  logic [4:0]  mmioOpm,
  output logic [1:0]  mmioOK,
  output logic        ps2tx_irq
);

  localparam logic [1:0] UMEM_OK_READY = 2'b00;
  localparam logic [1:0] UMEM_OK_OK    = 2'b01;
  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    BITS,
    ACK,
    WAITIDLE
  } state_t;

  state_t           state, stateNext;
  logic [INH_W-1:0] inhCnt, inhCntNext;
  logic [TMO_W-1:0] tmoCnt, tmoCntNext;
  logic [9:0]       frame, frameNext;
  logic [3:0]       bitCnt, bitCntNext;
  logic             clkDrive, clkDriveNext;
  logic             dataDrive, dataDriveNext;
  logic             busy, busyNext;
  logic             ackOk, ackOkNext;
  logic             err, errNext;
  logic             overrun, overrunNext;

  logic clkSync1, clkSync2, dataSync1, dataSync2;
  logic clkFall;
  logic sel, access, wrTx, rdStat;
  logic unusedBits;

  assign ps2_clk_o  = 1'b0;
  assign ps2_data_o = 1'b0;
  assign ps2_clk_d  = clkDrive;
  assign ps2_data_d = dataDrive;

  assign sel    = (mmioAddr[27:16] == 12'h000) && (mmioAddr[15:4] == 12'hE08);
  assign access = sel && (mmioOpm[3] || mmioOpm[4]);
  assign wrTx   = sel && mmioOpm[4] && (mmioAddr[3:0] == 4'h0);
  assign rdStat = sel && mmioOpm[3] && (mmioAddr[3:0] == 4'h4);
  assign clkFall = clkSync2 && !clkSync1;

  assign unusedBits = ^{mmioInData[31:8], mmioAddr[31:28], mmioOpm[2:0]};

  // Synchronisers reset to the idle (released, high) line level so no false edge follows reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      clkSync1  <= 1'b1;
      clkSync2  <= 1'b1;
      dataSync1 <= 1'b1;
      dataSync2 <= 1'b1;
    end else begin
      clkSync1  <= ps2_clk_i;
      clkSync2  <= clkSync1;
      dataSync1 <= ps2_data_i;
      dataSync2 <= dataSync1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      inhCnt    <= '0;
      tmoCnt    <= '0;
      frame     <= '0;
      bitCnt    <= '0;
      clkDrive  <= 1'b0;
      dataDrive <= 1'b0;
      busy      <= 1'b0;
      ackOk     <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= stateNext;
      inhCnt    <= inhCntNext;
      tmoCnt    <= tmoCntNext;
      frame     <= frameNext;
      bitCnt    <= bitCntNext;
      clkDrive  <= clkDriveNext;
      dataDrive <= dataDriveNext;
      busy      <= busyNext;
      ackOk     <= ackOkNext;
      err       <= errNext;
      overrun   <= overrunNext;
    end
  end

  always_comb begin
    stateNext     = state;
    inhCntNext    = inhCnt;
    tmoCntNext    = tmoCnt;
    frameNext     = frame;
    bitCntNext    = bitCnt;
    clkDriveNext  = clkDrive;
    dataDriveNext = dataDrive;
    busyNext      = busy;
    ackOkNext     = ackOk;
    errNext       = err;
    overrunNext   = overrun;

    // Read-clear happens first so a status event in the same cycle is not lost.
    if (rdStat) begin
      errNext     = 1'b0;
      overrunNext = 1'b0;
    end
    if (wrTx && (state != IDLE)) begin
      overrunNext = 1'b1;
    end

    case (state)
      IDLE: begin
        if (wrTx) begin
          frameNext     = {1'b1, ~^mmioInData[7:0], mmioInData[7:0]};
          ackOkNext     = 1'b0;
          errNext       = 1'b0;
          busyNext      = 1'b1;
          inhCntNext    = '0;
          clkDriveNext  = 1'b1;
          dataDriveNext = 1'b0;
          stateNext     = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inhCnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          clkDriveNext  = 1'b0;
          dataDriveNext = 1'b1;
          stateNext     = RTS;
        end else begin
          inhCntNext = inhCnt + 1'b1;
        end
      end
      RTS: begin
        tmoCntNext = TMO_W'(TIMEOUT_CYCLES);
        bitCntNext = '0;
        stateNext  = BITS;
      end
      BITS: begin
        if (clkFall) begin
          dataDriveNext = ~frame[0];
          frameNext     = {1'b0, frame[9:1]};
          if (bitCnt == 4'd9) begin
            stateNext = ACK;
          end else begin
            bitCntNext = bitCnt + 1'b1;
          end
        end
      end
      ACK: begin
        if (clkFall) begin
          if (!dataSync1) begin
            ackOkNext = 1'b1;
          end else begin
            errNext = 1'b1;
          end
          stateNext = WAITIDLE;
        end
      end
      WAITIDLE: begin
        if (clkSync2 && dataSync2) begin
          busyNext  = 1'b0;
          stateNext = IDLE;
        end
      end
      default: begin
        clkDriveNext  = 1'b0;
        dataDriveNext = 1'b0;
        busyNext      = 1'b0;
        stateNext     = IDLE;
      end
    endcase

    // Timeout overrides whatever the frame states decided this cycle.
    if ((state == BITS) || (state == ACK) || (state == WAITIDLE)) begin
      if (tmoCnt == '0) begin
        clkDriveNext  = 1'b0;
        dataDriveNext = 1'b0;
        errNext       = 1'b1;
        busyNext      = 1'b0;
        stateNext     = IDLE;
      end else begin
        tmoCntNext = tmoCnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mmioOK      <= UMEM_OK_READY;
      mmioOutData <= '0;
    end else begin
      mmioOK      <= access ? UMEM_OK_OK : UMEM_OK_READY;
      mmioOutData <= rdStat ? {28'b0, overrun, err, ackOk, busy} : '0;
    end
  end

`ifdef PS2TX_IRQ_EN
  logic irq;

  // Completion wins over a simultaneous STATUS read so the event is never dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      irq <= 1'b0;
    end else if (busy && !busyNext) begin
      irq <= 1'b1;
    end else if (rdStat) begin
      irq <= 1'b0;
    end
  end

  assign ps2tx_irq = irq;
`else
  assign ps2tx_irq = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with an open-drain PS/2 device model and a status reference model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned INH = 40;
  localparam int unsigned TMO = 2000;
  localparam logic [31:0] TXADDR = 32'h0000_E080;
  localparam logic [31:0] STADDR = 32'h0000_E084;
  localparam logic [1:0]  OK_READY = 2'b00;
  localparam logic [1:0]  OK_OK    = 2'b01;
`ifdef PS2TX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        devClk = 1'b1;
  logic        devData = 1'b1;
  logic        ps2_clk_o, ps2_clk_d, ps2_data_o, ps2_data_d;
  logic        clkPin, dataPin;
  logic [31:0] mmioInData = '0;
  logic [31:0] mmioAddr = '0;
  logic [4:0]  mmioOpm = '0;
  logic [31:0] mmioOutData;
  logic [1:0]  mmioOK;
  logic        ps2tx_irq;

  int unsigned vecCount = 0;
  int unsigned missCount = 0;
  int unsigned lowRun = 0;
  int unsigned lastLow = 0;

  // Reference status model
  logic mAck = 1'b0, mErr = 1'b0, mOvr = 1'b0;

  assign clkPin  = (ps2_clk_d  ? ps2_clk_o  : 1'b1) & devClk;
  assign dataPin = (ps2_data_d ? ps2_data_o : 1'b1) & devData;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .ps2_clk_i(clkPin), .ps2_clk_o(ps2_clk_o), .ps2_clk_d(ps2_clk_d),
    .ps2_data_i(dataPin), .ps2_data_o(ps2_data_o), .ps2_data_d(ps2_data_d),
    .mmioInData(mmioInData), .mmioOutData(mmioOutData), .mmioAddr(mmioAddr),
    .mmioOpm(mmioOpm), .mmioOK(mmioOK), .ps2tx_irq(ps2tx_irq)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ps2_clk_d) begin
      lowRun = lowRun + 1;
    end else begin
      if (lowRun != 0) lastLow = lowRun;
      lowRun = 0;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] refBits(input logic [7:0] b);
    logic [9:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[i];
    r[8] = ($countones(b) % 2 == 0);
    r[9] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] expStatus(input logic busyExp);
    return {28'b0, mOvr, mErr, mAck, busyExp};
  endfunction

  task automatic mmioWrite(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    mmioAddr = a; mmioInData = d; mmioOpm = 5'b10000;
    @(negedge clock);
    mmioAddr = '0; mmioInData = '0; mmioOpm = '0;
  endtask

  task automatic mmioRead(input logic [31:0] a, output logic [31:0] d, output logic [1:0] ok);
    @(negedge clock);
    mmioAddr = a; mmioOpm = 5'b01000;
    @(negedge clock);
    d = mmioOutData; ok = mmioOK;
    mmioAddr = '0; mmioOpm = '0;
  endtask

  task automatic readStatus(input string tag, input logic busyExp);
    logic [31:0] d;
    logic [1:0]  ok;
    mmioRead(STADDR, d, ok);
    checkVal(tag, d, expStatus(busyExp));
    mErr = 1'b0;
    mOvr = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit withOvr);
    mmioWrite(TXADDR, {24'b0, b});
    mAck = 1'b0;
    mErr = 1'b0;
    if (withOvr) begin
      repeat (5) @(negedge clock);
      mmioWrite(TXADDR, $urandom);
      mOvr = 1'b1;
    end
  endtask

  // Device side: waits for request-to-send, clocks 11 cycles, samples bits on rising edges.
  task automatic deviceFrame(input int halfPer, input bit doAck, input int abortAt,
                             output logic [9:0] got, output bit found);
    got = '0;
    found = 1'b0;
    for (int c = 0; c < int'(INH) + 100; c++) begin
      @(negedge clock);
      if (ps2_data_d && !ps2_clk_d) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) return;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && doAck) devData = 1'b0;
      repeat (halfPer) @(negedge clock);
      devClk = 1'b0;
      if (abortAt == k) begin
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        devClk = 1'b1;
        return;
      end
      repeat (halfPer) @(negedge clock);
      if (k <= 10) got[k-1] = dataPin;
      devClk = 1'b1;
    end
    devData = 1'b1;
  endtask

  task automatic fullFrame(input string tag, input logic [7:0] b, input int halfPer, input bit doAck);
    logic [9:0] got;
    bit found;
    deviceFrame(halfPer, doAck, 0, got, found);
    checkVal({tag, "Rts"}, found, 1'b1);
    checkVal({tag, "Bits"}, got, refBits(b));
    checkVal({tag, "Inhibit"}, lastLow >= INH, 1'b1);
    if (doAck) mAck = 1'b1; else mErr = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  ok;
    logic [9:0]  got;
    bit          found;
    logic [7:0]  b;

    repeat (3) @(negedge clock);
    checkVal("rstDrv", {ps2_clk_d, ps2_data_d}, 2'b00);
    checkVal("rstOK", mmioOK, OK_READY);
    checkVal("rstData", mmioOutData, '0);
    checkVal("rstIrq", ps2tx_irq, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    readStatus("idleStat", 1'b0);
    mmioRead(32'h0001_E084, d, ok);
    checkVal("unselOK", ok, OK_READY);
    checkVal("unselData", d, '0);
    mmioRead(32'h0000_E184, d, ok);
    checkVal("unselLoOK", ok, OK_READY);
    mmioRead(STADDR, d, ok);
    checkVal("selOK", ok, OK_OK);

    // 0xED acked
    sendByte(8'hED, 1'b0);
    fullFrame("ed", 8'hED, 20, 1'b1);
    checkVal("edIrq", ps2tx_irq, IRQ_ON);
    readStatus("edStat", 1'b0);
    checkVal("edIrqClr", ps2tx_irq, 1'b0);

    // 0xF4 acked with a mid-frame status poll
    sendByte(8'hF4, 1'b0);
    fork
      deviceFrame(20, 1'b1, 0, got, found);
      begin
        repeat (INH + 200) @(negedge clock);
        mmioRead(STADDR, d, ok);
      end
    join
    checkVal("f4Busy", d, 32'h1);
    checkVal("f4Bits", got, refBits(8'hF4));
    checkVal("f4Parity", got[8], 1'b0);
    mAck = 1'b1;
    repeat (10) @(negedge clock);
    readStatus("f4Stat", 1'b0);

    // 0xFF, no ack
    sendByte(8'hFF, 1'b0);
    fullFrame("ff", 8'hFF, 15, 1'b0);
    checkVal("ffIrq", ps2tx_irq, IRQ_ON);
    readStatus("ffStat", 1'b0);
    readStatus("ffStat2", 1'b0);

    // 0x00, device silent -> timeout
    sendByte(8'h00, 1'b0);
    repeat (INH + TMO + 50) @(negedge clock);
    checkVal("tmoDrv", {ps2_clk_d, ps2_data_d}, 2'b00);
    mErr = 1'b1;
    checkVal("tmoIrq", ps2tx_irq, IRQ_ON);
    readStatus("tmoStat", 1'b0);

    // overrun during inhibit
    sendByte(8'hED, 1'b1);
    fullFrame("ovr", 8'hED, 20, 1'b1);
    readStatus("ovrStat", 1'b0);
    readStatus("ovrStat2", 1'b0);

    // reset at edge 5
    sendByte(8'hA5, 1'b0);
    deviceFrame(20, 1'b1, 5, got, found);
    checkVal("abortDrv", {ps2_clk_d, ps2_data_d}, 2'b00);
    checkVal("abortIrq", ps2tx_irq, 1'b0);
    mAck = 1'b0; mErr = 1'b0; mOvr = 1'b0;
    readStatus("abortStat", 1'b0);

    for (int n = 0; n < 10; n++) begin
      bit doAck, doOvr;
      int hp;
      b = 8'($urandom);
      doAck = ($urandom_range(0, 3) != 0);
      doOvr = ($urandom_range(0, 1) != 0);
      hp = int'($urandom_range(8, 25));
      sendByte(b, doOvr);
      fullFrame("rnd", b, hp, doAck);
      checkVal("rndIrq", ps2tx_irq, IRQ_ON);
      readStatus("rndStat", 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
